// File: rtl/dbg_trace_buffer.sv
// Circular trace buffer for the CPU debug bus, read out byte-wise through SEL/LED.
// Optional capture trigger on an instruction match: DBG_TRACE_TRIGGER_EN.
module dbg_trace_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter bit WRAP       = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic                  STOP,
  input  logic [31:0]           dbg_inst,
  input  logic [2:0]            dbg_op,
  input  logic                  dbg_we,
  input  logic [31:0]           alu_output,
  input  logic                  RD_NEXT,
  input  logic [2:0]            SEL,
`ifdef DBG_TRACE_TRIGGER_EN
  input  logic [31:0]           TRIG_INST,
`endif
  output logic [7:0]            LED,
  output logic [3:0]            RD_TAG,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  OVF,
  output logic [1:0]            STATE
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] CNT_LAST = CNT_FULL - 1'b1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CAPTURE = 2'd1, S_DRAIN = 2'd2, S_ARMED = 2'd3} state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  ovf_q;
  logic [67:0]           mem [DEPTH];

  logic empty, full, start_ok, trig_hit;
  logic do_clear, do_write, do_pop, overwrite;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_FULL);
  assign start_ok = START && !STOP;

`ifdef DBG_TRACE_TRIGGER_EN
  assign trig_hit = (dbg_inst == TRIG_INST);
`else
  assign trig_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
`ifdef DBG_TRACE_TRIGGER_EN
        if (start_ok) state_d = S_ARMED;
`else
        if (start_ok) state_d = S_CAPTURE;
`endif
      end
      S_CAPTURE: begin
        if (STOP)                          state_d = S_DRAIN;
        else if (!WRAP && count_q >= CNT_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
`ifdef DBG_TRACE_TRIGGER_EN
        if (start_ok) state_d = S_ARMED;
`else
        if (start_ok) state_d = S_CAPTURE;
`endif
        else if (RD_NEXT && count_q == 1) state_d = S_IDLE;
      end
      S_ARMED: begin
        if (STOP)          state_d = S_IDLE;
        else if (trig_hit) state_d = S_CAPTURE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath controls decoded from the current state
  always_comb begin
    do_clear  = 1'b0;
    do_write  = 1'b0;
    do_pop    = 1'b0;
    case (state_q)
      S_IDLE, S_DRAIN: begin
        do_clear = start_ok;
        do_pop   = RD_NEXT && !empty && !start_ok;
      end
      S_CAPTURE: do_write = !STOP && !(full && !WRAP);
      S_ARMED:   do_write = !STOP && trig_hit;
      default: ;
    endcase
    overwrite = do_write && full;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (do_clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        // Full with WRAP: the write lands on the head, so the head moves on
        if (overwrite) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          ovf_q    <= 1'b1;
        end else begin
          count_q  <= count_q + 1'b1;
        end
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q  <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (do_write) mem[wr_ptr_q] <= {dbg_inst, alu_output, dbg_we, dbg_op};
  end

  logic [67:0] head;
  logic [31:0] head_word;
  logic [7:0]  head_byte;

  assign head      = mem[rd_ptr_q];
  assign head_word = SEL[2] ? head[35:4] : head[67:36];
  assign head_byte = head_word[{SEL[1:0], 3'b000} +: 8];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      LED    <= '0;
      RD_TAG <= '0;
    end else begin
      LED    <= empty ? 8'h00 : head_byte;
      RD_TAG <= empty ? 4'h0  : head[3:0];
    end
  end

  assign COUNT = count_q;
  assign EMPTY = empty;
  assign FULL  = full;
  assign OVF   = ovf_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_dbg_trace_buffer.sv
// Scoreboard bench: two buffers (WRAP=0 as "a", WRAP=1 as "b") share capture inputs.
module tb_dbg_trace_buffer;

  logic        CLK = 1'b0;
  logic        RST_N, START, STOP, dbg_we, rd_a, rd_b;
  logic [31:0] dbg_inst, alu_output;
  logic [2:0]  dbg_op, SEL;
`ifdef DBG_TRACE_TRIGGER_EN
  logic [31:0] trig_inst;
`endif

  logic [7:0] led_a, led_b;
  logic [3:0] tag_a, tag_b;
  logic [4:0] cnt_a, cnt_b;
  logic       empty_a, empty_b, full_a, full_b, ovf_a, ovf_b;
  logic [1:0] state_a, state_b;

  always #5 CLK = ~CLK;

  dbg_trace_buffer #(.DEPTH_LOG2(4), .WRAP(1'b0)) u_a (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP),
    .dbg_inst(dbg_inst), .dbg_op(dbg_op), .dbg_we(dbg_we), .alu_output(alu_output),
    .RD_NEXT(rd_a), .SEL(SEL),
`ifdef DBG_TRACE_TRIGGER_EN
    .TRIG_INST(trig_inst),
`endif
    .LED(led_a), .RD_TAG(tag_a), .COUNT(cnt_a), .EMPTY(empty_a), .FULL(full_a),
    .OVF(ovf_a), .STATE(state_a));

  dbg_trace_buffer #(.DEPTH_LOG2(4), .WRAP(1'b1)) u_b (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP),
    .dbg_inst(dbg_inst), .dbg_op(dbg_op), .dbg_we(dbg_we), .alu_output(alu_output),
    .RD_NEXT(rd_b), .SEL(SEL),
`ifdef DBG_TRACE_TRIGGER_EN
    .TRIG_INST(trig_inst),
`endif
    .LED(led_b), .RD_TAG(tag_b), .COUNT(cnt_b), .EMPTY(empty_b), .FULL(full_b),
    .OVF(ovf_b), .STATE(state_b));

  localparam int SIG_STATE = 0, SIG_CNT = 1, SIG_EMPTY = 2, SIG_FULL = 3,
                 SIG_LED = 4, SIG_TAG = 5, SIG_OVF = 6;

  typedef struct {
    string       name;
    int          inst;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [31:0] actual(int inst, int sig);
    logic [31:0] v;
    v = '0;
    case (sig)
      SIG_STATE: v = (inst == 0) ? 32'(state_a) : 32'(state_b);
      SIG_CNT:   v = (inst == 0) ? 32'(cnt_a)   : 32'(cnt_b);
      SIG_EMPTY: v = (inst == 0) ? 32'(empty_a) : 32'(empty_b);
      SIG_FULL:  v = (inst == 0) ? 32'(full_a)  : 32'(full_b);
      SIG_LED:   v = (inst == 0) ? 32'(led_a)   : 32'(led_b);
      SIG_TAG:   v = (inst == 0) ? 32'(tag_a)   : 32'(tag_b);
      SIG_OVF:   v = (inst == 0) ? 32'(ovf_a)   : 32'(ovf_b);
      default:   v = 32'hDEAD_BEEF;
    endcase
    return v;
  endfunction

  task automatic expect_val(input string name, input int inst, input int sig, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.inst = inst;
    e.sig  = sig;
    e.exp  = v;
    sb.push_back(e);
  endtask

  // Monitor: outputs are stable on the falling edge; compare everything queued
  always @(negedge CLK) begin
    exp_t        e;
    logic [31:0] got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = actual(e.inst, e.sig);
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("FAIL %s (%s): got 0x%0h expected 0x%0h", e.name, (e.inst == 0) ? "a" : "b", got, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] n);
    dbg_inst   = 32'h2008_0000 + n;
    alu_output = 32'hA5C3_1000 | n;
    dbg_we     = ~n[0];
    dbg_op     = n[2:0];
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b1; STOP = 1'b0; rd_a = 1'b0; rd_b = 1'b0; SEL = 3'd0;
    drive(32'd0);
`ifdef DBG_TRACE_TRIGGER_EN
    trig_inst = 32'h0022_1820;
`endif
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      expect_val("rst_state", i, SIG_STATE, 32'd0);
      expect_val("rst_count", i, SIG_CNT, 32'd0);
      expect_val("rst_empty", i, SIG_EMPTY, 32'd1);
      expect_val("rst_led", i, SIG_LED, 32'h00);
    end
    tick();
    RST_N = 1'b1; START = 1'b0;
    tick();

    // Capture 20 words; a stops at full, b wraps over the oldest four
    START = 1'b1; tick(); START = 1'b0;
    for (int n = 0; n < 20; n++) begin
      drive(32'(n));
      tick();
    end
    STOP = 1'b1; tick(); STOP = 1'b0; tick();
    expect_val("fill_count", 0, SIG_CNT, 32'd16);
    expect_val("fill_full", 0, SIG_FULL, 32'd1);
    expect_val("fill_state", 0, SIG_STATE, 32'd2);
    expect_val("fill_ovf", 0, SIG_OVF, 32'd0);
    expect_val("fill_tag", 0, SIG_TAG, 32'h8);
    expect_val("fill_led_sel0", 0, SIG_LED, 32'h00);
    expect_val("wrap_count", 1, SIG_CNT, 32'd16);
    expect_val("wrap_ovf", 1, SIG_OVF, 32'd1);
    expect_val("wrap_state", 1, SIG_STATE, 32'd2);
    expect_val("wrap_full", 1, SIG_FULL, 32'd1);
    expect_val("wrap_head", 1, SIG_LED, 32'h04);
    expect_val("wrap_tag", 1, SIG_TAG, 32'hC);
    SEL = 3'd3; tick();
    expect_val("led_sel3", 0, SIG_LED, 32'h20);
    expect_val("led_sel3", 1, SIG_LED, 32'h20);
    SEL = 3'd5; tick();
    expect_val("led_sel5", 0, SIG_LED, 32'h10);
    SEL = 3'd7; tick();
    expect_val("led_sel7", 0, SIG_LED, 32'hA5);
    SEL = 3'd4; tick();
    expect_val("led_sel4", 1, SIG_LED, 32'h04);
    SEL = 3'd0; tick();

    // Drain a in order
    for (int k = 0; k < 16; k++) begin
      logic [31:0] kv;
      kv = 32'(k);
      expect_val($sformatf("drain_led%0d", k), 0, SIG_LED, kv);
      expect_val($sformatf("drain_tag%0d", k), 0, SIG_TAG, {28'd0, ~kv[0], kv[2:0]});
      rd_a = 1'b1; tick(); rd_a = 1'b0; tick();
    end
    expect_val("drained_empty", 0, SIG_EMPTY, 32'd1);
    expect_val("drained_state", 0, SIG_STATE, 32'd0);
    expect_val("drained_count", 0, SIG_CNT, 32'd0);
    expect_val("drained_led", 0, SIG_LED, 32'h00);
    rd_a = 1'b1; tick(); rd_a = 1'b0; tick();
    expect_val("underflow_count", 0, SIG_CNT, 32'd0);
    expect_val("underflow_empty", 0, SIG_EMPTY, 32'd1);

    // START+STOP together: STOP wins in IDLE and in DRAIN
    START = 1'b1; STOP = 1'b1; tick(); START = 1'b0; STOP = 1'b0; tick();
    expect_val("startstop_state", 0, SIG_STATE, 32'd0);
    expect_val("startstop_count", 0, SIG_CNT, 32'd0);
    expect_val("startstop_state", 1, SIG_STATE, 32'd2);
    expect_val("startstop_count", 1, SIG_CNT, 32'd16);

    rd_b = 1'b1; tick(); rd_b = 1'b0; tick();
    expect_val("pop_count", 1, SIG_CNT, 32'd15);
    expect_val("pop_head", 1, SIG_LED, 32'h05);

    // Short capture ended by STOP; b restarts from DRAIN and loses OVF
    START = 1'b1; tick(); START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h30 + 32'(i));
      tick();
    end
    STOP = 1'b1; tick(); STOP = 1'b0; tick();
    expect_val("short_count", 0, SIG_CNT, 32'd3);
    expect_val("short_state", 0, SIG_STATE, 32'd2);
    expect_val("short_full", 0, SIG_FULL, 32'd0);
    expect_val("short_led", 0, SIG_LED, 32'h30);
    expect_val("short_count", 1, SIG_CNT, 32'd3);
    expect_val("short_ovf", 1, SIG_OVF, 32'd0);

    // Reset mid-capture
    START = 1'b1; tick(); START = 1'b0;
    drive(32'h40); tick(); tick();
    RST_N = 1'b0; #1;
    expect_val("abort_state", 0, SIG_STATE, 32'd0);
    expect_val("abort_count", 0, SIG_CNT, 32'd0);
    expect_val("abort_led", 0, SIG_LED, 32'h00);
    expect_val("abort_count", 1, SIG_CNT, 32'd0);
    tick();
    RST_N = 1'b1; tick();

`ifdef DBG_TRACE_TRIGGER_EN
    START = 1'b1; tick(); START = 1'b0;
    expect_val("armed_state", 0, SIG_STATE, 32'd3);
    for (int i = 0; i < 3; i++) begin
      dbg_inst = 32'h1111_0000 + 32'(i);
      tick();
      expect_val("armed_count", 0, SIG_CNT, 32'd0);
    end
    dbg_inst = 32'h0022_1820; tick();
    expect_val("trig_state", 0, SIG_STATE, 32'd1);
    expect_val("trig_count", 0, SIG_CNT, 32'd1);
    dbg_inst = 32'h0000_0055; tick();
    expect_val("trig_led0", 0, SIG_LED, 32'h20);
    SEL = 3'd1; tick();
    expect_val("trig_led1", 0, SIG_LED, 32'h18);
`endif

    repeat (4) tick();
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
